// File: rtl/wb_pkg.sv
// Shared Wishbone widths, responder state encoding and the default out-of-range read word.
package wb_pkg;

    localparam int WB_AW   = 32;
    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;

    localparam logic [WB_DW-1:0] OOR_DATA_DEFAULT = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_mem_bytearray.sv
// Word memory with synchronous per-byte write enables and combinational read.
module wb_mem_bytearray
   import wb_pkg::*;
#(
   parameter int    MEM_WORDS = 4096,
   parameter string INIT_FILE = "",
   localparam int   AW        = $clog2(MEM_WORDS)
) (
   input  logic               clk,
   input  logic [AW-1:0]      i_idx,
   input  logic [WB_SELW-1:0] i_byteWe,
   input  logic [WB_DW-1:0]   i_wrData,
   output logic [WB_DW-1:0]   o_rdData
);

   logic [WB_DW-1:0] r_mem [MEM_WORDS];

   // Each enabled byte lane is written on the rising edge; disabled lanes keep their contents.
   always_ff @(posedge clk) begin
      for (int b = 0; b < WB_SELW; b++) begin
         if (i_byteWe[b]) r_mem[i_idx][8*b +: 8] <= i_wrData[8*b +: 8];
      end
   end

   assign o_rdData = r_mem[i_idx];

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone classic responder with byte-writable memory, programmable wait states and range check.
// Define WB_MEM_RESPONDER_ERR_EN to signal out-of-range accesses on wb_err instead of wb_ack.
module wb_mem_responder
    import wb_pkg::*;
#(
    parameter int               MEM_WORDS   = 4096,
    parameter logic [WB_AW-1:0] BASE_ADR    = 32'h00000000,
    parameter int               WAIT_STATES = 0,
    parameter logic [WB_DW-1:0] OOR_DATA    = OOR_DATA_DEFAULT,
    parameter string            INIT_FILE   = ""
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_cyc,
    input  logic               wb_stb,
    input  logic [WB_AW-1:0]   wb_adr,
    input  logic               wb_we,
    input  logic [WB_SELW-1:0] wb_sel,
    input  logic [WB_DW-1:0]   wb_datw,
    output logic               wb_ack,
    output logic [WB_DW-1:0]   wb_datr,
    output logic [15:0]        acc_cnt
`ifdef WB_MEM_RESPONDER_ERR_EN
    ,
    output logic               wb_err
`endif
);

    localparam int         AW        = $clog2(MEM_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    wb_state_t          r_state;
    wb_state_t          w_nextState;
    logic [3:0]         r_cnt;
    logic [3:0]         w_nextCnt;

    logic [WB_AW-1:2]   r_adr;
    logic               r_we;
    logic [WB_SELW-1:0] r_sel;
    logic [WB_DW-1:0]   r_datw;

    logic               r_ack;
    logic [WB_DW-1:0]   r_datr;
    logic [15:0]        r_accCnt;

    logic               w_req;
    logic               w_enterAck;
    logic [WB_AW-1:2]   w_adr;
    logic               w_we;
    logic [WB_SELW-1:0] w_sel;
    logic [WB_DW-1:0]   w_datw;
    logic [WB_AW-3:0]   w_wordOff;
    logic               w_inRange;
    logic [WB_SELW-1:0] w_byteWe;
    logic [WB_DW-1:0]   w_rdData;
    logic [1:0]         w_unusedAdr;

    assign w_unusedAdr = wb_adr[1:0];
    assign w_req       = wb_cyc & wb_stb;

    // With zero wait states the access completes on the capture edge, so use the live bus fields.
    assign w_adr  = (r_state == S_IDLE) ? wb_adr[WB_AW-1:2] : r_adr;
    assign w_we   = (r_state == S_IDLE) ? wb_we             : r_we;
    assign w_sel  = (r_state == S_IDLE) ? wb_sel            : r_sel;
    assign w_datw = (r_state == S_IDLE) ? wb_datw           : r_datw;

    assign w_wordOff  = w_adr - BASE_ADR[WB_AW-1:2];
    assign w_inRange  = (w_wordOff < (WB_AW-2)'(MEM_WORDS));
    assign w_enterAck = (w_nextState == S_ACK);
    assign w_byteWe   = (w_enterAck && w_we && w_inRange) ? w_sel : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (WAIT_STATES == 0) begin
                        w_nextState = S_ACK;
                    end else begin
                        w_nextState = S_WAIT;
                        w_nextCnt   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (!wb_cyc) begin
                    w_nextState = S_IDLE;
                    w_nextCnt   = 4'd0;
                end else if (r_cnt == 4'd0) begin
                    w_nextState = S_ACK;
                end else begin
                    w_nextCnt = r_cnt - 4'd1;
                end
            end
            S_ACK:   w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_adr  <= '0;
            r_we   <= 1'b0;
            r_sel  <= '0;
            r_datw <= '0;
        end else if (r_state == S_IDLE && w_req) begin
            r_adr  <= wb_adr[WB_AW-1:2];
            r_we   <= wb_we;
            r_sel  <= wb_sel;
            r_datw <= wb_datw;
        end
    end

    wb_mem_bytearray #(
        .MEM_WORDS (MEM_WORDS),
        .INIT_FILE (INIT_FILE)
    ) u_mem (
        .clk      (clk),
        .i_idx    (w_wordOff[AW-1:0]),
        .i_byteWe (w_byteWe),
        .i_wrData (w_datw),
        .o_rdData (w_rdData)
    );

    // Response is registered on the edge entering ACK; read data is forced to zero outside the ack cycle.
`ifdef WB_MEM_RESPONDER_ERR_EN
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_datr   <= '0;
            r_accCnt <= 16'd0;
        end else begin
            r_ack  <= w_enterAck && w_inRange;
            r_err  <= w_enterAck && !w_inRange;
            r_datr <= (w_enterAck && !w_we && w_inRange) ? w_rdData : '0;
            if (w_enterAck) r_accCnt <= r_accCnt + 16'd1;
        end
    end

    assign wb_err = r_err;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack    <= 1'b0;
            r_datr   <= '0;
            r_accCnt <= 16'd0;
        end else begin
            r_ack  <= w_enterAck;
            r_datr <= (w_enterAck && !w_we) ? (w_inRange ? w_rdData : OOR_DATA) : '0;
            if (w_enterAck) r_accCnt <= r_accCnt + 16'd1;
        end
    end
`endif

    assign wb_ack  = r_ack;
    assign wb_datr = r_datr;
    assign acc_cnt = r_accCnt;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Bench for wb_mem_responder: one instance with no wait states and one with three, sharing a bus.
// Honours WB_MEM_RESPONDER_ERR_EN when the design is built with it.
module tb_wb_mem_responder;
    import wb_pkg::*;

`ifdef WB_MEM_RESPONDER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] datw;
        logic [31:0] expDatr;
        logic        oor;
    } vec_t;

    typedef struct {
        logic [31:0] datr;
        logic        chkDat;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        cyc;
    logic        stb;
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] datw;
    logic        dutSel;

    logic        cyc0, stb0, cyc3, stb3;
    logic        ack0, ack3;
    logic [31:0] datr0, datr3;
    logic [15:0] acc0, acc3;
    logic        ack, err;
    logic [31:0] datr;
    logic [15:0] acc;

    int          checkCount;
    int          passCount;
    int          expAcc [2];
    exp_t        sbQ [$];
    vec_t        vecs [18];

    assign cyc0 = cyc & ~dutSel;
    assign stb0 = stb & ~dutSel;
    assign cyc3 = cyc & dutSel;
    assign stb3 = stb & dutSel;

    assign ack  = dutSel ? ack3 : ack0;
    assign datr = dutSel ? datr3 : datr0;
    assign acc  = dutSel ? acc3 : acc0;

`ifdef WB_MEM_RESPONDER_ERR_EN
    logic err0, err3;
    assign err = dutSel ? err3 : err0;
`else
    assign err = 1'b0;
`endif

    wb_mem_responder #(.MEM_WORDS(4096), .BASE_ADR(32'h0), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .wb_cyc(cyc0), .wb_stb(stb0), .wb_adr(adr), .wb_we(we),
        .wb_sel(sel), .wb_datw(datw), .wb_ack(ack0), .wb_datr(datr0), .acc_cnt(acc0)
`ifdef WB_MEM_RESPONDER_ERR_EN
        , .wb_err(err0)
`endif
    );

    wb_mem_responder #(.MEM_WORDS(4096), .BASE_ADR(32'h0), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst), .wb_cyc(cyc3), .wb_stb(stb3), .wb_adr(adr), .wb_we(we),
        .wb_sel(sel), .wb_datw(datw), .wb_ack(ack3), .wb_datr(datr3), .acc_cnt(acc3)
`ifdef WB_MEM_RESPONDER_ERR_EN
        , .wb_err(err3)
`endif
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] expv);
        checkCount++;
        if (act === expv) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    endtask

    // Waits for ack or err, checking that read data stays zero until then; lat=-1 on timeout.
    task automatic waitResponse(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ack || err) begin
                lat = i;
                break;
            end
            compare("datrBeforeAck", datr, 32'h0);
        end
        if (lat < 0) begin
            checkCount++;
            $display("[TB] FAIL responseTimeout: no ack/err within 40 cycles, required a response");
        end
    endtask

    task automatic checkOutput(input int lat);
        exp_t e;
        if (sbQ.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL scoreboardEmpty: response seen with no expectation queued");
            return;
        end
        e = sbQ.pop_front();
        compare("latency", 32'(lat), 32'(e.lat));
        compare("ack", {31'b0, ack}, {31'b0, !e.err});
        compare("err", {31'b0, err}, {31'b0, e.err});
        if (e.chkDat) compare("datr", datr, e.datr);
        expAcc[dutSel]++;
    endtask

    function automatic exp_t makeExp(input logic w, input logic [31:0] expD, input logic oor);
        exp_t e;
        e.err    = ERR_EN && oor;
        e.chkDat = !w || e.err;
        e.datr   = e.err ? 32'h0 : expD;
        e.lat    = dutSel ? 5 : 2;
        return e;
    endfunction

    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [3:0] s,
                                 input logic [31:0] d, input logic [31:0] expD, input logic oor);
        int lat;
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; datw = d;
        sbQ.push_back(makeExp(w, expD, oor));
        waitResponse(lat);
        cyc = 1'b0; stb = 1'b0;
        checkOutput(lat);
        @(negedge clk);
        compare("ackOneCycle", {31'b0, ack | err}, 32'h0);
        compare("datrAfterAck", datr, 32'h0);
        compare("accCnt", {16'b0, acc}, {16'b0, 16'(expAcc[dutSel])});
    endtask

    initial begin
        int lat;
        int hits;

        checkCount = 0; passCount = 0;
        expAcc[0] = 0; expAcc[1] = 0;
        cyc = 0; stb = 0; we = 0; adr = 0; sel = 0; datw = 0; dutSel = 0;

        vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'h1122_3344, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'h1122_3344, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0010, 4'h5, 32'hAABB_CCDD, 32'h0,         1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'h11BB_33DD, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0014, 4'hF, 32'h5566_7788, 32'h0,         1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0014, 4'h0, 32'hFFFF_FFFF, 32'h0,         1'b0};
        vecs[6]  = '{1'b0, 32'h0000_0014, 4'hF, 32'h0,         32'h5566_7788, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000_0000, 4'hF, 32'hA5A5_A5A5, 32'h0,         1'b0};
        vecs[8]  = '{1'b1, 32'h0000_4000, 4'hF, 32'h1234_5678, 32'h0,         1'b1};
        vecs[9]  = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         32'hA5A5_A5A5, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_4000, 4'hF, 32'h0,         32'hDEAD_BEEF, 1'b1};
        vecs[11] = '{1'b1, 32'h0000_3FFC, 4'hF, 32'h0BAD_F00D, 32'h0,         1'b0};
        vecs[12] = '{1'b0, 32'h0000_3FFC, 4'hF, 32'h0,         32'h0BAD_F00D, 1'b0};
        vecs[13] = '{1'b0, 32'h0000_0013, 4'hF, 32'h0,         32'h11BB_33DD, 1'b0};
        vecs[14] = '{1'b1, 32'h0000_0010, 4'h8, 32'h7700_0000, 32'h0,         1'b0};
        vecs[15] = '{1'b1, 32'h0000_0010, 4'h2, 32'h0000_EE00, 32'h0,         1'b0};
        vecs[16] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'h77BB_EEDD, 1'b0};
        vecs[17] = '{1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0,         32'hDEAD_BEEF, 1'b1};

        // Reset state of both instances.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        compare("rstAck0", {31'b0, ack0}, 32'h0);
        compare("rstDatr0", datr0, 32'h0);
        compare("rstAcc3", {16'b0, acc3}, 32'h0);
        rst = 1'b0;

        $display("[TB] table vectors, no wait states");
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].datw,
                          vecs[i].expDatr, vecs[i].oor);
        end

        $display("[TB] back-to-back reads, strobe held across ack");
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 0; adr = 32'h10; sel = 4'hF;
        sbQ.push_back(makeExp(1'b0, 32'h77BB_EEDD, 1'b0));
        waitResponse(lat);
        adr = 32'h14;
        checkOutput(lat);
        sbQ.push_back(makeExp(1'b0, 32'h5566_7788, 1'b0));
        waitResponse(lat);
        cyc = 0; stb = 0;
        checkOutput(lat);

        $display("[TB] three wait states");
        dutSel = 1'b1;
        applyStimulus(1'b1, 32'h20, 4'hF, 32'h0102_0304, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h20, 4'hF, 32'h0, 32'h0102_0304, 1'b0);
        applyStimulus(1'b0, 32'h4000, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b1);

        $display("[TB] captured fields ignored during wait");
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 0; adr = 32'h20; sel = 4'hF;
        sbQ.push_back(makeExp(1'b0, 32'h0102_0304, 1'b0));
        @(negedge clk);
        @(negedge clk);
        adr = 32'h4000; datw = 32'hFFFF_FFFF;
        waitResponse(lat);
        cyc = 0; stb = 0;
        checkOutput(lat + 2);

        $display("[TB] abort during wait");
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 1; adr = 32'h20; sel = 4'hF; datw = 32'hCAFE_F00D;
        @(negedge clk);
        @(negedge clk);
        cyc = 0; stb = 0;
        hits = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack || err) hits++;
        end
        compare("abortNoAck", 32'(hits), 32'h0);
        compare("abortAccCnt", {16'b0, acc}, {16'b0, 16'(expAcc[1])});
        applyStimulus(1'b0, 32'h20, 4'hF, 32'h0, 32'h0102_0304, 1'b0);

        $display("[TB] reset during wait");
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 1; adr = 32'h20; sel = 4'hF; datw = 32'h5A5A_5A5A;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        compare("rstWaitAck", {31'b0, ack}, 32'h0);
        compare("rstWaitDatr", datr, 32'h0);
        compare("rstWaitAcc", {16'b0, acc}, 32'h0);
        expAcc[0] = 0; expAcc[1] = 0;
        cyc = 0; stb = 0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 32'h20, 4'hF, 32'h0, 32'h0102_0304, 1'b0);

        $display("[TB] reset during ack cycle");
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 0; adr = 32'h20; sel = 4'hF;
        waitResponse(lat);
        compare("ackBeforeRst", {31'b0, ack}, 32'h1);
        rst = 1'b1;
        #1;
        compare("rstAckAsync", {31'b0, ack}, 32'h0);
        compare("rstDatrAsync", datr, 32'h0);
        cyc = 0; stb = 0;
        expAcc[0] = 0; expAcc[1] = 0;
        @(negedge clk);
        rst = 1'b0;
        dutSel = 1'b0;
        applyStimulus(1'b0, 32'h14, 4'hF, 32'h0, 32'h5566_7788, 1'b0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
